reg_file: RTL and testbench
===========================

# reg_file

General-purpose register file of the MIPS datapath, directly upstream of the ALU. It holds 32 × 32-bit registers and drives the ALU `a` and `b` operands from two combinational read ports. One synchronous write port takes the write-back result. Writes carrying a signed-overflow indication from the ALU are suppressed and latched as a sticky exception flag.

## Interface
Parameters:
- `DATA_W`, 32, register and port data width
- `ADDR_W`, 5, register index width (2^ADDR_W registers)

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `we`  in  1  write enable for the write-back result
- `waddr`  in  ADDR_W  destination register index
- `wdata`  in  DATA_W  write-back data (ALU `result` or memory data)
- `wov`  in  1  ALU overflow (`ov`) qualifying this write; 1 = suppress write
- `raddr1`  in  ADDR_W  read port 1 index (rs)
- `raddr2`  in  ADDR_W  read port 2 index (rt)
- `rdata1`  out  DATA_W  read port 1 data; drives ALU `a`
- `rdata2`  out  DATA_W  read port 2 data; drives ALU `b`
- `exc_clr`  in  1  clears `ov_exc`
- `ov_exc`  out  1  sticky overflow-exception flag
- `ov_addr`  out  ADDR_W  destination index of the first suppressed write

## Operation
- Storage: 2^ADDR_W registers of DATA_W bits.
- Register 0 is hard-wired to zero:
  - Writes to index 0 are discarded, whatever the state of `wov`.
  - Reads of index 0 return 0.
  - A write to index 0 with `wov`=1 still sets `ov_exc`.
- Write commit: on a rising edge with `we`=1, `wov`=0 and `waddr`≠0, `wdata` is stored at `waddr`.
- Overflow suppression: on a rising edge with `we`=1 and `wov`=1:
  - No register changes.
  - `ov_exc` ← 1.
  - `ov_addr` ← `waddr`, only if `ov_exc` was 0 beforehand. The first exception is kept until cleared.
- `wov` is ignored when `we`=0.
- Clear: `exc_clr`=1 at a rising edge sets `ov_exc` ← 0 and `ov_addr` ← 0.
  - If `exc_clr` and a suppressed write occur on the same edge, set wins: `ov_exc`=1 and `ov_addr` takes the new `waddr`.
- Reads are combinational from the current storage. Both ports may address the same register.
- Arithmetic: none. Data passes through unmodified at full DATA_W width; no sign or zero extension.

## Timing
- Reset (`rst_n`=0, asynchronous): all registers ← 0, `ov_exc` ← 0, `ov_addr` ← 0.
  - Consequence: `rdata1` and `rdata2` read 0 for every index during and after reset.
- Reset asserted mid-write: the write is lost; reset dominates `we`.
- Deassertion of `rst_n` is expected synchronous to `clk`. The first commit happens on the first rising edge with `rst_n`=1.
- Write latency: 1 cycle. Data written at edge N is visible on the read ports after edge N.
- Read latency: 0 cycles (combinational) from `raddr*` to `rdata*`.
- Same-cycle read of a register being written: behaviour is set by `REGFILE_BYPASS_EN` (see Configuration).

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: write-through bypass.
  - If `we`=1, `wov`=0, `waddr`≠0 and `raddrX`==`waddr`, then `rdataX` = `wdata` combinationally in the same cycle.
  - Serves the WB→ID hazard without a separate forwarding path.
  - A suppressed write (`wov`=1) is never bypassed.
- Undefined: `rdataX` returns the stored (old) value until the edge commits; the new value appears the following cycle.

## Structure
- Shared package `mips_pkg` holds:
  - `DATA_W` = 32 and `REG_ADDR_W` = 5 as localparams.
  - `REG_ZERO` = 5'd0.
  - Typedefs `word_t` (DATA_W) and `reg_idx_t` (REG_ADDR_W).
- One sub-module is natural: `rf_read_port`.
  - Instantiated twice.
  - Contains the index-0 zero mux and, under `REGFILE_BYPASS_EN`, the bypass compare/mux.
- Storage, write logic and exception flag live in `reg_file`.

## Test plan
- Reset, then read all 32 indices on both ports → every read returns 32'h0, `ov_exc`=0, `ov_addr`=0.
- Write 32'h0000_86E4 to r5 and 32'h0004_F3C4 to r6, read raddr1=5 and raddr2=6 next cycle → rdata1=32'h86E4, rdata2=32'h4F3C4. Write 32'hFFFF_FFFF to r0 → r0 still reads 0.
- Same cycle, `we`=1, waddr=7, wdata=32'hDEAD_BEEF, raddr1=7:
  - With `REGFILE_BYPASS_EN`, rdata1=32'hDEADBEEF immediately.
  - Without it, rdata1=old value, then 32'hDEADBEEF after the edge.
- r9 holds 32'h1234. Write r9 with wdata=32'h8000_0000 and wov=1 → r9 still 32'h1234, `ov_exc`=1, `ov_addr`=9. A second suppressed write to r3 leaves `ov_addr`=9.
- Assert `exc_clr` on the same edge as a suppressed write to r4 → `ov_exc`=1, `ov_addr`=4. Assert `exc_clr` alone → `ov_exc`=0, `ov_addr`=0.
- Write r10=32'hA5A5, drop `rst_n` mid-cycle while `we`=1 targets r11 → immediately r10=0 and r11=0. After release, r11 stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
//
// Contents:
//   DATA_W, REG_ADDR_W  datapath word width and register index width
//   REG_ZERO            index of the hard-wired zero register
//   word_t, reg_idx_t   matching data and index types
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of the register file.
//
// Returns the stored word for raddr, forcing 0 for the zero register. When the
// REGFILE_BYPASS_EN macro is defined, a committing write to the same index in
// the current cycle is forwarded to rdata (write-through).
//
// Ports:
//   raddr     in   read index
//   stored    in   word currently held in storage at raddr
//   byp_en    in   a write commits at the next edge (we & ~wov & waddr != 0)
//   byp_addr  in   index of that write
//   byp_data  in   data of that write
//   rdata     out  read data
module rf_read_port #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] stored,
  input  logic              byp_en,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0] byp_data,
  output logic [DATA_W-1:0] rdata
);
  import mips_pkg::*;

  localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(REG_ZERO);

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rdata = stored;
    if (raddr == ZeroIdx) begin
      rdata = '0;
    end else if (byp_en && (byp_addr == raddr)) begin
      rdata = byp_data;
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_en, byp_addr, byp_data};

  always_comb begin
    rdata = stored;
    if (raddr == ZeroIdx) begin
      rdata = '0;
    end
  end
`endif

endmodule

// File: rtl/reg_file.sv
// MIPS general-purpose register file: 2^ADDR_W x DATA_W storage, two
// combinational read ports feeding the ALU operands, one synchronous write
// port for write-back. Writes flagged with ALU overflow (wov) are dropped and
// recorded in a sticky exception flag with the index of the first one.
//
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-through
// on both read ports.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   we, waddr, wdata write-back port
//   wov              overflow qualifier for the write (1 = suppress)
//   raddr1, rdata1   read port 1 (ALU a)
//   raddr2, rdata2   read port 2 (ALU b)
//   exc_clr          clears ov_exc / ov_addr
//   ov_exc           sticky overflow exception
//   ov_addr          destination index of the first suppressed write
module reg_file #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wov,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              exc_clr,
  output logic              ov_exc,
  output logic [ADDR_W-1:0] ov_addr
);
  import mips_pkg::*;

  localparam int unsigned       NumRegs = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroIdx = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic              ov_exc_q, ov_exc_d;
  logic [ADDR_W-1:0] ov_addr_q, ov_addr_d;

  logic wr_commit;
  logic wr_suppress;

  assign wr_commit   = we && !wov && (waddr != ZeroIdx);
  // Index 0 still raises the exception even though the data is discarded.
  assign wr_suppress = we && wov;

  always_comb begin
    ov_exc_d  = ov_exc_q;
    ov_addr_d = ov_addr_q;
    if (exc_clr) begin
      ov_exc_d  = 1'b0;
      ov_addr_d = '0;
    end
    // Set beats clear; only the first exception since the last clear is kept.
    if (wr_suppress) begin
      if (!ov_exc_d) begin
        ov_addr_d = waddr;
      end
      ov_exc_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q    <= '{default: '0};
      ov_exc_q  <= 1'b0;
      ov_addr_q <= '0;
    end else begin
      if (wr_commit) begin
        regs_q[waddr] <= wdata;
      end
      ov_exc_q  <= ov_exc_d;
      ov_addr_q <= ov_addr_d;
    end
  end

  assign ov_exc  = ov_exc_q;
  assign ov_addr = ov_addr_q;

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd1 (
    .raddr    (raddr1),
    .stored   (regs_q[raddr1]),
    .byp_en   (wr_commit),
    .byp_addr (waddr),
    .byp_data (wdata),
    .rdata    (rdata1)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd2 (
    .raddr    (raddr2),
    .stored   (regs_q[raddr2]),
    .byp_en   (wr_commit),
    .byp_addr (waddr),
    .byp_data (wdata),
    .rdata    (rdata2)
  );

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wov;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        exc_clr;
  logic        ov_exc;
  logic [4:0]  ov_addr;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  reg_file dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .wov     (wov),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .exc_clr (exc_clr),
    .ov_exc  (ov_exc),
    .ov_addr (ov_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain architectural state.
  logic [31:0] m_regs [32];
  logic        m_exc;
  logic [4:0]  m_addr;

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (Bypass && we && !wov && waddr == idx) return wdata;
    return m_regs[idx];
  endfunction

  // Applied at each rising edge with the inputs that were presented.
  task automatic m_edge();
    logic       nexc;
    logic [4:0] naddr;
    nexc  = exc_clr ? 1'b0 : m_exc;
    naddr = exc_clr ? 5'd0 : m_addr;
    if (we && wov) begin
      if (!nexc) naddr = waddr;
      nexc = 1'b1;
    end
    if (we && !wov && waddr != 5'd0) m_regs[waddr] = wdata;
    m_exc  = nexc;
    m_addr = naddr;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_exc  = 1'b0;
    m_addr = 5'd0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    we = 1'b0; wov = 1'b0; exc_clr = 1'b0; waddr = 5'd0; wdata = 32'h0;
  endtask

  // One clocked operation: present inputs, take the edge, update the model.
  task automatic clock_op();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wov;
    logic        clr;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eexc;
    logic [4:0]  eaddr;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{"wr_r5",        1, 5'd5,  32'h0000_86E4, 0, 0, 5'd5, 5'd6, 32'h86E4, 32'h0,     0, 5'd0};
    vecs[1]  = '{"wr_r6",        1, 5'd6,  32'h0004_F3C4, 0, 0, 5'd5, 5'd6, 32'h86E4, 32'h4F3C4, 0, 5'd0};
    vecs[2]  = '{"wr_r0",        1, 5'd0,  32'hFFFF_FFFF, 0, 0, 5'd0, 5'd5, 32'h0,    32'h86E4,  0, 5'd0};
    vecs[3]  = '{"wr_r9",        1, 5'd9,  32'h0000_1234, 0, 0, 5'd9, 5'd9, 32'h1234, 32'h1234,  0, 5'd0};
    vecs[4]  = '{"ov_r9",        1, 5'd9,  32'h8000_0000, 1, 0, 5'd9, 5'd0, 32'h1234, 32'h0,     1, 5'd9};
    vecs[5]  = '{"ov_r3_sticky", 1, 5'd3,  32'h0000_5555, 1, 0, 5'd3, 5'd9, 32'h0,    32'h1234,  1, 5'd9};
    vecs[6]  = '{"wov_no_we",    0, 5'd12, 32'h0000_0077, 1, 0, 5'd12, 5'd3, 32'h0,   32'h0,     1, 5'd9};
    vecs[7]  = '{"clr_and_set",  1, 5'd4,  32'h0000_0044, 1, 1, 5'd4, 5'd6, 32'h0,    32'h4F3C4, 1, 5'd4};
    vecs[8]  = '{"clr_alone",    0, 5'd0,  32'h0,         0, 1, 5'd4, 5'd5, 32'h0,    32'h86E4,  0, 5'd0};
    vecs[9]  = '{"ov_r0",        1, 5'd0,  32'h0000_0001, 1, 0, 5'd0, 5'd9, 32'h0,    32'h1234,  1, 5'd0};
    vecs[10] = '{"ov_after_r0",  1, 5'd7,  32'h0000_0002, 1, 0, 5'd7, 5'd0, 32'h0,    32'h0,     1, 5'd0};
    vecs[11] = '{"clr_final",    0, 5'd0,  32'h0,         0, 1, 5'd9, 5'd6, 32'h1234, 32'h4F3C4, 0, 5'd0};
  end

  initial begin
    logic [4:0] ra;
    idle_inputs();
    raddr1 = 5'd0; raddr2 = 5'd0;
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state on every index of both ports.
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      check($sformatf("rst_rd1[%0d]", i), rdata1, 32'h0);
      check($sformatf("rst_rd2[%0d]", 31 - i), rdata2, 32'h0);
    end
    check("rst_ov_exc", {31'h0, ov_exc}, 32'h0);
    check("rst_ov_addr", {27'h0, ov_addr}, 32'h0);

    // Directed table: apply op, take edge, read back with write disabled.
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      wov = vecs[i].wov; exc_clr = vecs[i].clr;
      clock_op();
      idle_inputs();
      raddr1 = vecs[i].ra1; raddr2 = vecs[i].ra2;
      #1;
      check({vecs[i].name, "_rd1"}, rdata1, vecs[i].e1);
      check({vecs[i].name, "_rd2"}, rdata2, vecs[i].e2);
      check({vecs[i].name, "_exc"}, {31'h0, ov_exc}, {31'h0, vecs[i].eexc});
      check({vecs[i].name, "_addr"}, {27'h0, ov_addr}, {27'h0, vecs[i].eaddr});
    end

    // Same-cycle read of a register being written (r7 currently 0).
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF; raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    check("same_cycle_rd1", rdata1, Bypass ? 32'hDEAD_BEEF : 32'h0);
    check("same_cycle_rd2", rdata2, Bypass ? 32'hDEAD_BEEF : 32'h0);
    clock_op();
    idle_inputs();
    #1;
    check("after_edge_rd1", rdata1, 32'hDEAD_BEEF);

    // A suppressed write is never forwarded.
    we = 1'b1; wov = 1'b1; waddr = 5'd7; wdata = 32'h0000_0001;
    #1;
    check("no_byp_on_ov", rdata1, 32'hDEAD_BEEF);
    clock_op();
    idle_inputs();
    #1;
    check("ov_keeps_r7", rdata1, 32'hDEAD_BEEF);
    check("ov_r7_addr", {27'h0, ov_addr}, 32'd7);

    // Reset asserted mid-cycle during a write.
    we = 1'b1; waddr = 5'd10; wdata = 32'h0000_A5A5;
    clock_op();
    we = 1'b1; waddr = 5'd11; wdata = 32'h0000_1111; raddr1 = 5'd10; raddr2 = 5'd11;
    #1;
    check("pre_rst_r10", rdata1, 32'h0000_A5A5);
    #1;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("rst_mid_r10", rdata1, 32'h0);
    check("rst_mid_r11", rdata2, 32'h0);
    check("rst_mid_exc", {31'h0, ov_exc}, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    clock_op();
    check("post_rst_r11", rdata2, 32'h0);
    check("post_rst_r10", rdata1, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      we      = ($urandom_range(0, 9) < 7);
      wov     = ($urandom_range(0, 9) < 2);
      exc_clr = ($urandom_range(0, 9) == 0);
      waddr   = 5'($urandom_range(0, 31));
      wdata   = $urandom();
      ra      = 5'($urandom_range(0, 31));
      raddr1  = ($urandom_range(0, 3) == 0) ? waddr : ra;
      raddr2  = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      #2;
      check($sformatf("rnd%0d_rd1", n), rdata1, m_read(raddr1));
      check($sformatf("rnd%0d_rd2", n), rdata2, m_read(raddr2));
      clock_op();
      check($sformatf("rnd%0d_exc", n), {31'h0, ov_exc}, {31'h0, m_exc});
      check($sformatf("rnd%0d_addr", n), {27'h0, ov_addr}, {27'h0, m_addr});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
